// File: rtl/trace_arb_pkg.sv
// trace_arb_pkg: shared types and constants for the trace stream arbiter.
// Holds the arbiter state enum, source count, message delimiters, the
// optional message length limit, and a saturating counter increment.
package trace_arb_pkg;

   localparam int unsigned NUM_SRC     = 4;
   localparam logic [7:0]  CH_START    = 8'h5E;  // '^'
   localparam logic [7:0]  CH_END      = 8'h23;  // '#'
   localparam int unsigned MSG_MAX_LEN = 64;

   typedef enum logic [2:0] {
      StIdle,
      StStream,
      StDrain,
      StCheck,
      StClear
   } arb_state_e;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   req    in  4  request per source
//   ptr    in  2  highest-priority source index
//   gnt_id out 2  first requesting source at or after ptr (wrapping)
//   any    out 1  at least one request present
module rr_picker
   import trace_arb_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] gnt_id,
   output logic       any
);

   logic [1:0] cand;

   // Walk from the farthest offset down to ptr so the nearest requester wins.
   always_comb begin
      gnt_id = ptr;
      cand   = ptr;
      any    = |req;
      for (int unsigned i = NUM_SRC; i > 0; i--) begin
         cand = ptr + 2'(i - 1);
         if (req[cand]) begin
            gnt_id = cand;
         end
      end
   end

endmodule

// File: rtl/trace_stream_arbiter.sv
// trace_stream_arbiter: serialises whole '^'...'#' messages from four sources
// onto one downstream format checker, holding the grant for a full message,
// then tallies the checker verdict into saturating counters.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   src_valid/src_char per-source char valid and chars (source i at [8i+7:8i])
//   src_ready          one-hot accept to the granted source while streaming
//   chk_char           registered char to the checker (0 when not passing one)
//   chk_reset          checker reset (reset or CLEAR state)
//   fmt_type           checker verdict: 01 reg-write, 10 mem-write, else error
//   grant_id, busy     granted source, message in progress
//   reg_cnt/mem_cnt/err_cnt  saturating message counters
// Configuration: define ARB_MSGLEN_LIMIT_EN to abort messages whose 64th
// transferred char is not '#'.
module trace_stream_arbiter
   import trace_arb_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  src_valid,
   input  logic [31:0] src_char,
   output logic [3:0]  src_ready,
   output logic [7:0]  chk_char,
   output logic        chk_reset,
   input  logic [1:0]  fmt_type,
   output logic [1:0]  grant_id,
   output logic        busy,
   output logic [15:0] reg_cnt,
   output logic [15:0] mem_cnt,
   output logic [15:0] err_cnt
);

   arb_state_e  state_q, state_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic [1:0]  grant_q, grant_d;
   logic [7:0]  chk_char_q, chk_char_d;
   logic [15:0] reg_cnt_q, reg_cnt_d;
   logic [15:0] mem_cnt_q, mem_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic [1:0]  pick_id;
   logic        pick_any;
   logic [7:0]  cur_char;
   logic        len_abort;

   rr_picker u_rr_picker (
      .req    (src_valid),
      .ptr    (rr_ptr_q),
      .gnt_id (pick_id),
      .any    (pick_any)
   );

   assign cur_char = src_char[{grant_q, 3'b000} +: 8];

`ifdef ARB_MSGLEN_LIMIT_EN
   logic [5:0] len_q, len_d;

   // len_q counts chars already transferred; the one now in flight is len_q+1.
   assign len_abort = (len_q == 6'(MSG_MAX_LEN - 1)) && (cur_char != CH_END);

   always_comb begin
      len_d = len_q;
      if (state_q == StIdle) begin
         len_d = '0;
      end else if (state_q == StStream && src_valid[grant_q]) begin
         len_d = len_q + 6'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q <= '0;
      end else begin
         len_q <= len_d;
      end
   end
`else
   assign len_abort = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      chk_char_d = 8'h00;
      reg_cnt_d  = reg_cnt_q;
      mem_cnt_d  = mem_cnt_q;
      err_cnt_d  = err_cnt_q;
      src_ready  = 4'b0000;
      case (state_q)
         StIdle: begin
            if (pick_any) begin
               grant_d = pick_id;
               state_d = StStream;
            end
         end
         StStream: begin
            src_ready[grant_q] = 1'b1;
            if (src_valid[grant_q]) begin
               chk_char_d = cur_char;
               if (cur_char == CH_END) begin
                  state_d = StDrain;
               end else if (len_abort) begin
                  err_cnt_d = sat_inc(err_cnt_q);
                  state_d   = StClear;
               end
            end else begin
               // A bubble mid-message aborts without consulting the checker.
               err_cnt_d = sat_inc(err_cnt_q);
               state_d   = StClear;
            end
         end
         StDrain: state_d = StCheck;
         StCheck: begin
            case (fmt_type)
               2'b01:   reg_cnt_d = sat_inc(reg_cnt_q);
               2'b10:   mem_cnt_d = sat_inc(mem_cnt_q);
               default: err_cnt_d = sat_inc(err_cnt_q);
            endcase
            state_d = StClear;
         end
         StClear: begin
            rr_ptr_d = grant_q + 2'd1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         chk_char_q <= '0;
         reg_cnt_q  <= '0;
         mem_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         chk_char_q <= chk_char_d;
         reg_cnt_q  <= reg_cnt_d;
         mem_cnt_q  <= mem_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign chk_char  = chk_char_q;
   assign chk_reset = reset | (state_q == StClear);
   assign busy      = (state_q != StIdle);
   assign grant_id  = grant_q;
   assign reg_cnt   = reg_cnt_q;
   assign mem_cnt   = mem_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_trace_stream_arbiter.sv
// tb_trace_stream_arbiter: directed self-checking bench for trace_stream_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_trace_stream_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  src_valid;
   logic [31:0] src_char;
   logic [3:0]  src_ready;
   logic [7:0]  chk_char;
   logic        chk_reset;
   logic [1:0]  fmt_type;
   logic [1:0]  grant_id;
   logic        busy;
   logic [15:0] reg_cnt;
   logic [15:0] mem_cnt;
   logic [15:0] err_cnt;

   int total = 0;
   int bad   = 0;

   trace_stream_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .src_valid (src_valid),
      .src_char  (src_char),
      .src_ready (src_ready),
      .chk_char  (chk_char),
      .chk_reset (chk_reset),
      .fmt_type  (fmt_type),
      .grant_id  (grant_id),
      .busy      (busy),
      .reg_cnt   (reg_cnt),
      .mem_cnt   (mem_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      reset     = 1'b1;
      src_valid = 4'b0000;
      src_char  = 32'h0;
      fmt_type  = 2'b01;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Streams m from source s, one char per accepted cycle, and reports char
   // errors seen on chk_char, the grant seen, and any stray ready bit.
   task automatic drive_msg(input int s, input string m, input bit hold,
                            output int nbad, output int gid,
                            output bit other_rdy, output bit timeout);
      int idx;
      int cyc;
      bit r;
      idx = 0; cyc = 0;
      nbad = 0; gid = -1; other_rdy = 1'b0; timeout = 1'b0;
      while (idx < m.len()) begin
         if (cyc >= 300) begin
            timeout = 1'b1;
            break;
         end
         src_valid[s]        = 1'b1;
         src_char[8*s +: 8]  = m[idx];
         r = src_ready[s];
         if ((src_ready & ~(4'b0001 << s)) != 4'b0000) other_rdy = 1'b1;
         if (r && gid < 0) gid = int'(grant_id);
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (r) begin
            if (chk_char !== m[idx]) nbad++;
            idx++;
         end
      end
      if (!hold) src_valid[s] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; src_valid = 4'hF; src_char = 32'h5E5E5E5E; fmt_type = 2'b01;
      repeat (2) @(negedge clk);
      total++; if (chk_reset !== 1'b1) begin bad++; $display("FAIL rst_chk_reset got=%0b want=1", chk_reset); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
      total++; if (src_ready !== 4'h0) begin bad++; $display("FAIL rst_ready got=%0h want=0", src_ready); end
      total++; if (grant_id !== 2'd0 || chk_char !== 8'h00) begin
         bad++; $display("FAIL rst_grant_char got=%0d/%0h want=0/0", grant_id, chk_char); end
      total++; if ({reg_cnt, mem_cnt, err_cnt} !== 48'h0) begin
         bad++; $display("FAIL rst_counters got=%0h/%0h/%0h want=0", reg_cnt, mem_cnt, err_cnt); end
      src_valid = 4'h0;
      reset = 1'b0;
      @(negedge clk);
      total++; if (chk_reset !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL rst_release got=%0b/%0b want=0/0", chk_reset, busy); end
   endtask

   task automatic test_reg_msg();
      int nbad, gid, pulses;
      bit oth, to;
      do_reset();
      fmt_type = 2'b01;
      drive_msg(0, "^10@00003000: $ 1 <= 0000000a#", 1'b0, nbad, gid, oth, to);
      total++; if (to || nbad != 0) begin
         bad++; $display("FAIL reg_chars got=timeout%0b/bad%0d want=0/0", to, nbad); end
      total++; if (gid != 0) begin bad++; $display("FAIL reg_grant got=%0d want=0", gid); end
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (chk_reset) pulses++;
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL reg_clear_pulses got=%0d want=1", pulses); end
      total++; if (reg_cnt !== 16'd1 || err_cnt !== 16'd0 || mem_cnt !== 16'd0) begin
         bad++; $display("FAIL reg_counts got=%0d/%0d/%0d want=1/0/0", reg_cnt, mem_cnt, err_cnt); end
   endtask

   task automatic test_round_robin();
      int nbad, gid;
      bit oth, to;
      do_reset();
      src_valid[2] = 1'b1;
      src_char[23:16] = 8'h5E;
      drive_msg(1, "^ab#", 1'b0, nbad, gid, oth, to);
      total++; if (gid != 1 || to) begin bad++; $display("FAIL rr_first got=%0d want=1", gid); end
      total++; if (oth !== 1'b0) begin bad++; $display("FAIL rr_no_other_ready got=%0b want=0", oth); end
      drive_msg(2, "^cd#", 1'b0, nbad, gid, oth, to);
      total++; if (gid != 2 || to || nbad != 0) begin
         bad++; $display("FAIL rr_second got=%0d/bad%0d want=2/0", gid, nbad); end
      wait_cycles(6);
      total++; if (reg_cnt !== 16'd2) begin bad++; $display("FAIL rr_reg_cnt got=%0d want=2", reg_cnt); end
   endtask

   task automatic test_all_four_wrap();
      int nbad, gid, s;
      bit oth, to;
      do_reset();
      drive_msg(1, "^#", 1'b0, nbad, gid, oth, to);  // leaves rr_ptr at 2
      wait_cycles(6);
      src_valid = 4'hF;
      src_char  = 32'h5E5E5E5E;
      for (int k = 0; k < 4; k++) begin
         s = (2 + k) % 4;
         drive_msg(s, "^z#", 1'b0, nbad, gid, oth, to);
         total++; if (gid != s || to || nbad != 0) begin
            bad++; $display("FAIL wrap_order_%0d got=%0d want=%0d", k, gid, s); end
      end
      wait_cycles(6);
      total++; if (reg_cnt !== 16'd5) begin bad++; $display("FAIL wrap_reg_cnt got=%0d want=5", reg_cnt); end
   endtask

   task automatic test_abort();
      int nbad, gid;
      bit oth, to;
      do_reset();
      drive_msg(3, "^abcd", 1'b0, nbad, gid, oth, to);
      total++; if (gid != 3 || busy !== 1'b1) begin
         bad++; $display("FAIL abort_grant got=%0d/busy%0b want=3/1", gid, busy); end
      @(negedge clk);
      total++; if (chk_reset !== 1'b1 || err_cnt !== 16'd1) begin
         bad++; $display("FAIL abort_clear got=%0b/err%0d want=1/1", chk_reset, err_cnt); end
      wait_cycles(2);
      total++; if (reg_cnt !== 16'd0 || mem_cnt !== 16'd0 || busy !== 1'b0) begin
         bad++; $display("FAIL abort_others got=%0d/%0d/busy%0b want=0/0/0", reg_cnt, mem_cnt, busy); end
   endtask

   task automatic test_mem_err();
      int nbad, gid;
      bit oth, to;
      do_reset();
      fmt_type = 2'b10;
      drive_msg(0, "*abc#", 1'b0, nbad, gid, oth, to);
      wait_cycles(6);
      total++; if (mem_cnt !== 16'd1 || err_cnt !== 16'd0) begin
         bad++; $display("FAIL mem_cnt got=%0d/err%0d want=1/0", mem_cnt, err_cnt); end
      fmt_type = 2'b00;
      drive_msg(0, "^bad#", 1'b0, nbad, gid, oth, to);
      wait_cycles(6);
      total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL fmt00_err got=%0d want=1", err_cnt); end
      fmt_type = 2'b11;
      drive_msg(0, "^bad#", 1'b0, nbad, gid, oth, to);
      wait_cycles(6);
      total++; if (err_cnt !== 16'd2 || reg_cnt !== 16'd0 || mem_cnt !== 16'd1) begin
         bad++; $display("FAIL fmt11_err got=%0d/%0d/%0d want=2/0/1", err_cnt, reg_cnt, mem_cnt); end
   endtask

   task automatic test_reset_mid_stream();
      int nbad, gid;
      bit oth, to;
      do_reset();
      drive_msg(0, "^ok#", 1'b0, nbad, gid, oth, to);
      wait_cycles(6);
      drive_msg(1, "^ab", 1'b1, nbad, gid, oth, to);
      total++; if (busy !== 1'b1 || reg_cnt !== 16'd1) begin
         bad++; $display("FAIL mid_pre got=busy%0b/reg%0d want=1/1", busy, reg_cnt); end
      reset = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0 || src_ready !== 4'h0 || chk_reset !== 1'b1) begin
         bad++; $display("FAIL mid_reset got=busy%0b/rdy%0h/cr%0b want=0/0/1", busy, src_ready, chk_reset); end
      total++; if ({reg_cnt, mem_cnt, err_cnt} !== 48'h0 || grant_id !== 2'd0) begin
         bad++; $display("FAIL mid_counters got=%0d/%0d/%0d/g%0d want=0", reg_cnt, mem_cnt, err_cnt, grant_id); end
      reset = 1'b0;
      src_valid = 4'h0;
      wait_cycles(3);
      total++; if (busy !== 1'b0 || err_cnt !== 16'd0) begin
         bad++; $display("FAIL mid_after got=busy%0b/err%0d want=0/0", busy, err_cnt); end
   endtask

   task automatic test_long_msg();
      string m;
      m = "^";
      for (int i = 0; i < 69; i++) m = {m, "a"};
      do_reset();
`ifdef ARB_MSGLEN_LIMIT_EN
      begin
         int xfers;
         bit r;
         xfers = 0;
         src_valid[0] = 1'b1;
         for (int c = 0; c < 200; c++) begin
            src_char[7:0] = m[(xfers < 70) ? xfers : 69];
            r = src_ready[0];
            @(posedge clk);
            @(negedge clk);
            if (r) xfers++;
            if (chk_reset) break;
         end
         src_valid[0] = 1'b0;
         total++; if (xfers != 64) begin bad++; $display("FAIL len_abort_char got=%0d want=64", xfers); end
         total++; if (err_cnt !== 16'd1 || reg_cnt !== 16'd0) begin
            bad++; $display("FAIL len_abort_err got=%0d/%0d want=1/0", err_cnt, reg_cnt); end
      end
`else
      begin
         int nbad, gid;
         bit oth, to;
         m = {m, "#"};
         fmt_type = 2'b01;
         drive_msg(0, m, 1'b0, nbad, gid, oth, to);
         total++; if (to || nbad != 0) begin
            bad++; $display("FAIL len_chars got=timeout%0b/bad%0d want=0/0", to, nbad); end
         wait_cycles(6);
         total++; if (reg_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            bad++; $display("FAIL len_no_limit got=%0d/%0d want=1/0", reg_cnt, err_cnt); end
      end
`endif
   endtask

   initial begin
      reset = 1'b1; src_valid = 4'h0; src_char = 32'h0; fmt_type = 2'b00;
      @(negedge clk);
      test_reset();
      test_reg_msg();
      test_round_robin();
      test_all_four_wrap();
      test_abort();
      test_mem_err();
      test_reset_mid_stream();
      test_long_msg();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trace_stream_arbiter.md
TRACE_STREAM_ARBITER -- requirements
Module: trace_stream_arbiter

Interface
REQ-001 SHALL have clock clk and reset reset (synchronous, active-high).
REQ-002 Ports, in order (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- src_valid  in  4  per-source char valid.
- src_char  in  32  source i char at bits [8i+7:8i].
- src_ready  out  4  per-source char accept.
- chk_char  out  8  char to downstream format checker.
- chk_reset  out  1  checker reset.
- fmt_type  in  2  checker verdict: 01 reg-write, 10 mem-write, 00 invalid.
- grant_id  out  2  granted source.
- busy  out  1  message in progress.
- reg_cnt  out  16  reg-write message count.
- mem_cnt  out  16  mem-write message count.
- err_cnt  out  16  bad/aborted message count.

Function
REQ-003 SHALL serialise whole messages ('^' … '#') from 4 sources onto one checker; grant held for a full message.
REQ-004 SHALL implement states IDLE, STREAM, DRAIN, CHECK, CLEAR.
REQ-005 IDLE: with any src_valid set, SHALL pick a source round-robin from rr_ptr, load grant_id, go STREAM next edge; otherwise stay.
REQ-006 STREAM: src_ready = one-hot(grant_id), all other bits 0; transfer = src_valid[g] & src_ready[g].
REQ-007 Each transferred char SHALL be registered into chk_char on the transfer edge (1-cycle latency); chk_char = 8'h00 in all other states.
REQ-008 Transfer of '#' (8'h23) SHALL move STREAM to DRAIN; DRAIN SHALL go to CHECK after one cycle.
REQ-009 CHECK (one cycle): on exit edge SHALL sample fmt_type: 01 -> reg_cnt+1; 10 -> mem_cnt+1; 00 or 11 -> err_cnt+1; then go CLEAR.
REQ-010 STREAM with src_valid[g]=0 (bubble) SHALL abort: err_cnt+1, go CLEAR, no CHECK.
REQ-011 CLEAR (one cycle) SHALL assert chk_reset, set rr_ptr = grant_id+1 (mod 4), go IDLE.
REQ-012 chk_reset = reset OR (state == CLEAR).
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 Counters SHALL saturate at 16'hFFFF.
REQ-015 Requests raised during a message SHALL wait; no preemption.
REQ-016 All four requesting with rr_ptr=k SHALL grant k, then k+1, … (wrap 3->0).

Reset
REQ-017 reset SHALL force IDLE, rr_ptr=0, grant_id=0, chk_char=0, src_ready=0, busy=0, all counters 0, chk_reset=1; takes priority over any in-flight message, which is discarded uncounted.

Configuration
REQ-018 Macro ARB_MSGLEN_LIMIT_EN defined: the 64th char transferred in one message without '#' SHALL abort as REQ-010 (err_cnt+1, CLEAR).
REQ-019 Macro ARB_MSGLEN_LIMIT_EN undefined: no length counter; messages of any length are accepted.

Structure
REQ-020 Shared package trace_arb_pkg SHALL hold the state enum, NUM_SRC=4, CH_START=8'h5E ('^'), CH_END=8'h23 ('#'), MSG_MAX_LEN=64.
REQ-021 Round-robin selection SHALL live in sub-module rr_picker: inputs req[3:0] and ptr[1:0]; outputs gnt_id[1:0] and any.

Verification
REQ-022 Source 0 sends "^10@00003000: $ 1 <= 0000000a#" back-to-back; checker returns 01 -> reg_cnt=1, err_cnt=0, chk_reset pulses once in CLEAR.
REQ-023 Sources 1 and 2 both valid from reset (rr_ptr=0) -> grant 1 first, then 2; src_ready[2]=0 throughout source 1's message.
REQ-024 Source 3 drops src_valid after 5 chars -> err_cnt=1, CLEAR next cycle, reg_cnt/mem_cnt unchanged.
REQ-025 Source 0 sends a "*…#" message and checker returns 10 -> mem_cnt=1; a malformed message returning 00 -> err_cnt=1.
REQ-026 reset asserted mid-STREAM -> next cycle IDLE, counters 0, src_ready=0; with ARB_MSGLEN_LIMIT_EN, a 70-char message without '#' -> abort on char 64, err_cnt=1.
